// File: rtl/axis_pkt_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axis_pkt_arbiter_if
// Description : AXI-Stream bundle used by the packet arbiter. A stream source
//               drives the bundle through the master modport. A stream sink
//               receives it through the slave modport.
// Ports       : tvalid / tready / tlast  handshake and end-of-packet
//               tdata [DATA_WIDTH]       payload
//               tid   [8]                source index (master side only)
// Revision    : 1.0  initial release
// ============================================================================
interface axis_pkt_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
    logic [7:0]            tid;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        output tid,
        input  tready
    );

    // Requester ports carry no stream id.
    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axis_pkt_arbiter
// Description : This is a two-requester AXI-Stream arbiter. It locks the grant
//               for a whole packet and breaks ties round-robin. While a port
//               holds the grant, its stream passes through to the shared output
//               combinationally. The arbiter also counts completed packets for
//               each requester.
// Ports       : ACLK, ARESET        clock, synchronous active-high reset
//               s0_axis, s1_axis    requester streams (slave modport)
//               m_axis              shared output stream (master modport)
//               BUSY                high while a grant is held
//               PKT_CNT0/PKT_CNT1   completed-packet counters (wrapping)
// Revision    : 1.0  initial release
// ============================================================================
module axis_pkt_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 ACLK,
    input  wire logic                 ARESET,
    axis_pkt_arbiter_if.slave         s0_axis,
    axis_pkt_arbiter_if.slave         s1_axis,
    axis_pkt_arbiter_if.master        m_axis,
    output logic                      BUSY,
    output logic [CNT_WIDTH-1:0]      PKT_CNT0,
    output logic [CNT_WIDTH-1:0]      PKT_CNT1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_last_grant;   // 1: port 0 wins the next tie
    logic                   r_busy;
    logic [CNT_WIDTH-1:0]   r_cnt0;
    logic [CNT_WIDTH-1:0]   r_cnt1;

    logic                   w_s0_ready;
    logic                   w_s1_ready;
    logic                   w_m_valid;
    logic                   w_m_last;
    logic [DATA_WIDTH-1:0]  w_m_data;
    logic [7:0]             w_m_tid;
    logic                   w_done0;
    logic                   w_done1;

    // ------------------------------------------------------------------------
    // Next-state and pass-through mux
    // ------------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_s0_ready = 1'b0;
        w_s1_ready = 1'b0;
        w_m_valid  = 1'b0;
        w_m_last   = 1'b0;
        w_m_data   = '0;
        w_m_tid    = 8'h00;
        w_done0    = 1'b0;
        w_done1    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Outputs stay quiet here. The grant takes effect on the next
                // edge, which gives the one-cycle arbitration latency and the
                // mandatory gap between packets.
                if (s0_axis.tvalid && s1_axis.tvalid) begin
                    w_next = r_last_grant ? ST_GNT0 : ST_GNT1;
                end else if (s0_axis.tvalid) begin
                    w_next = ST_GNT0;
                end else if (s1_axis.tvalid) begin
                    w_next = ST_GNT1;
                end
            end

            ST_GNT0: begin
                w_m_valid  = s0_axis.tvalid;
                w_m_data   = s0_axis.tdata;
                w_m_last   = s0_axis.tlast;
                w_m_tid    = 8'h00;
                w_s0_ready = m_axis.tready;
                w_done0    = s0_axis.tvalid & m_axis.tready & s0_axis.tlast;
                if (w_done0) begin
                    w_next = ST_IDLE;
                end
            end

            ST_GNT1: begin
                w_m_valid  = s1_axis.tvalid;
                w_m_data   = s1_axis.tdata;
                w_m_last   = s1_axis.tlast;
                w_m_tid    = 8'h01;
                w_s1_ready = m_axis.tready;
                w_done1    = s1_axis.tvalid & m_axis.tready & s1_axis.tlast;
                if (w_done1) begin
                    w_next = ST_IDLE;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, round-robin pointer, busy flag and packet counters
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);

            if (r_state == ST_IDLE && w_next == ST_GNT0) begin
                r_last_grant <= 1'b0;
            end else if (r_state == ST_IDLE && w_next == ST_GNT1) begin
                r_last_grant <= 1'b1;
            end

            if (w_done0) begin
                r_cnt0 <= r_cnt0 + C_CNT_ONE;
            end
            if (w_done1) begin
                r_cnt1 <= r_cnt1 + C_CNT_ONE;
            end
        end
    end

    assign s0_axis.tready = w_s0_ready;
    assign s1_axis.tready = w_s1_ready;
    assign m_axis.tvalid  = w_m_valid;
    assign m_axis.tdata   = w_m_data;
    assign m_axis.tlast   = w_m_last;
    assign m_axis.tid     = w_m_tid;
    assign BUSY           = r_busy;
    assign PKT_CNT0       = r_cnt0;
    assign PKT_CNT1       = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axis_pkt_arbiter
// Description : Self-checking bench for axis_pkt_arbiter. It keeps a
//               grant-owner model and checks it every cycle. It also checks
//               directed packet sequences against literal expectations. A
//               second instance with a 4-bit counter covers wrap-around.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axis_pkt_arbiter;

    localparam int DW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_pkt_arbiter_if #(.DATA_WIDTH(DW)) s0 ();
    axis_pkt_arbiter_if #(.DATA_WIDTH(DW)) s1 ();
    axis_pkt_arbiter_if #(.DATA_WIDTH(DW)) m ();
    logic          busy;
    logic [CW-1:0] cnt0, cnt1;

    axis_pkt_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .ACLK(clk), .ARESET(rst), .s0_axis(s0), .s1_axis(s1), .m_axis(m),
        .BUSY(busy), .PKT_CNT0(cnt0), .PKT_CNT1(cnt1)
    );

    axis_pkt_arbiter_if #(.DATA_WIDTH(DW)) w0 ();
    axis_pkt_arbiter_if #(.DATA_WIDTH(DW)) w1 ();
    axis_pkt_arbiter_if #(.DATA_WIDTH(DW)) wm ();
    logic       wbusy;
    logic [3:0] wcnt0, wcnt1;

    axis_pkt_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w (
        .ACLK(clk), .ARESET(rst), .s0_axis(w0), .s1_axis(w1), .m_axis(wm),
        .BUSY(wbusy), .PKT_CNT0(wcnt0), .PKT_CNT1(wcnt1)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ------------------------------------------------------------------------
    // Source drivers: present the head of a beat queue, pop on handshake
    // ------------------------------------------------------------------------
    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    beat_t q0[$];
    beat_t q1[$];

    initial begin
        logic hs;
        s0.tvalid = 1'b0; s0.tlast = 1'b0; s0.tdata = '0; s0.tid = 8'h00;
        forever begin
            @(negedge clk);
            hs = s0.tvalid && s0.tready;
            @(posedge clk);
            #1;
            if (hs) void'(q0.pop_front());
            if (q0.size() != 0) begin
                s0.tvalid = 1'b1; s0.tdata = q0[0].data; s0.tlast = q0[0].last;
            end else begin
                s0.tvalid = 1'b0; s0.tdata = '0; s0.tlast = 1'b0;
            end
        end
    end

    initial begin
        logic hs;
        s1.tvalid = 1'b0; s1.tlast = 1'b0; s1.tdata = '0; s1.tid = 8'h00;
        forever begin
            @(negedge clk);
            hs = s1.tvalid && s1.tready;
            @(posedge clk);
            #1;
            if (hs) void'(q1.pop_front());
            if (q1.size() != 0) begin
                s1.tvalid = 1'b1; s1.tdata = q1[0].data; s1.tlast = q1[0].last;
            end else begin
                s1.tvalid = 1'b0; s1.tdata = '0; s1.tlast = 1'b0;
            end
        end
    end

    // Output ready: mode 0 = always ready, mode 1 = repeating 1,0,0 pattern
    int rdy_mode = 0;
    int rdy_idx  = 0;
    initial begin
        m.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                m.tready = (rdy_idx % 3 == 0);
                rdy_idx++;
            end else begin
                m.tready = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sink recorder
    // ------------------------------------------------------------------------
    typedef struct { int tid; int data; int last; int cyc; } out_t;
    out_t oq[$];
    int   first_v1_cyc = -1;

    initial forever begin
        @(negedge clk);
        if (m.tvalid && m.tready)
            oq.push_back('{int'(m.tid), int'(m.tdata), int'(m.tlast), cyc});
        if (s1.tvalid && first_v1_cyc < 0)
            first_v1_cyc = cyc;
    end

    // ------------------------------------------------------------------------
    // Reference model: who owns the output, round-robin memory, packet counts
    // ------------------------------------------------------------------------
    int   own   = 2;   // 0 / 1 = port holding the grant, 2 = nobody
    int   lastg = 1;
    int   mc0   = 0;
    int   mc1   = 0;
    logic rst_s = 1'b1;

    initial forever begin
        @(posedge clk);
        rst_s = rst;
        if (rst) begin
            own = 2; lastg = 1; mc0 = 0; mc1 = 0;
        end else if (own == 2) begin
            if (s0.tvalid && s1.tvalid) own = 1 - lastg;
            else if (s0.tvalid)         own = 0;
            else if (s1.tvalid)         own = 1;
            if (own != 2) lastg = own;
        end else if (own == 0) begin
            if (s0.tvalid && m.tready && s0.tlast) begin
                mc0 = (mc0 + 1) % (1 << CW);
                own = 2;
            end
        end else begin
            if (s1.tvalid && m.tready && s1.tlast) begin
                mc1 = (mc1 + 1) % (1 << CW);
                own = 2;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        logic prev_stall;
        logic ev;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            ev = (own == 0) ? s0.tvalid : (own == 1) ? s1.tvalid : 1'b0;
            chk("m_tvalid",  m.tvalid,  ev);
            chk("s0_tready", s0.tready, (own == 0) ? m.tready : 1'b0);
            chk("s1_tready", s1.tready, (own == 1) ? m.tready : 1'b0);
            chk("m_tid",     m.tid,     (own == 1) ? 8'h01 : 8'h00);
            chk("busy",      busy,      own != 2);
            chk("pkt_cnt0",  cnt0,      mc0);
            chk("pkt_cnt1",  cnt1,      mc1);
            if (ev) begin
                chk("m_tdata", m.tdata, (own == 0) ? s0.tdata : s1.tdata);
                chk("m_tlast", m.tlast, (own == 0) ? s0.tlast : s1.tlast);
            end
            if (prev_stall && !rst_s)
                chk("m_tvalid_hold", m.tvalid, 1'b1);
            prev_stall = m.tvalid && !m.tready;
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    int ed[$];
    int et[$];

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, oq.size(), ed.size());
        for (int i = 0; i < ed.size(); i++) begin
            if (i < oq.size()) begin
                chk({tag, "_data"}, oq[i].data, ed[i]);
                chk({tag, "_tid"},  oq[i].tid,  et[i]);
            end
        end
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_m_tvalid",  m.tvalid,  1'b0);
        chk("rst_s0_tready", s0.tready, 1'b0);
        chk("rst_s1_tready", s1.tready, 1'b0);
        chk("rst_cnt0",      cnt0,      '0);
        chk("rst_cnt1",      cnt1,      '0);
        @(posedge clk);
        #1 rst = 1'b0;
        oq.delete();
        ed.delete();
        et.delete();
        first_v1_cyc = -1;
        #1;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q0.size() != 0 || q1.size() != 0 || busy) && n < maxc);
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, maxc);
        end
    endtask

    task automatic push(input int port, input int data, input logic last);
        if (port == 0) q0.push_back('{data, last});
        else           q1.push_back('{data, last});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------------
    initial begin
        int n;
        int prev;
        logic hs;
        logic seen_wrap;

        w0.tvalid = 1'b0; w0.tlast = 1'b0; w0.tdata = '0; w0.tid = 8'h00;
        w1.tvalid = 1'b0; w1.tlast = 1'b0; w1.tdata = '0; w1.tid = 8'h00;
        wm.tready = 1'b1;

        // Both ports with 4-beat packets; port 0 wins the first tie
        reset_dut();
        for (int i = 1; i <= 4; i++) push(0, i, i == 4);
        for (int i = 1; i <= 4; i++) push(1, 'h10 + i, i == 4);
        wait_done("t1", 60);
        ed = '{'h01, 'h02, 'h03, 'h04, 'h11, 'h12, 'h13, 'h14};
        et = '{0, 0, 0, 0, 1, 1, 1, 1};
        check_seq("t1");
        if (oq.size() >= 5) chk("t1_idle_gap", oq[4].cyc - oq[3].cyc, 2);
        chk("t1_cnt0", cnt0, 16'd1);
        chk("t1_cnt1", cnt1, 16'd1);

        // Only port 1 requests a 3-beat packet
        reset_dut();
        for (int i = 1; i <= 3; i++) push(1, 'h20 + i, i == 3);
        wait_done("t2", 40);
        ed = '{'h21, 'h22, 'h23};
        et = '{1, 1, 1};
        check_seq("t2");
        if (oq.size() >= 1) chk("t2_latency", oq[0].cyc - first_v1_cyc, 1);
        chk("t2_cnt0", cnt0, 16'd0);
        chk("t2_cnt1", cnt1, 16'd1);

        // Output back-pressure during a port-0 packet, port 1 waiting
        reset_dut();
        rdy_mode = 1;
        rdy_idx  = 0;
        for (int i = 1; i <= 5; i++) push(0, 'h30 + i, i == 5);
        push(1, 'h41, 1'b0);
        push(1, 'h42, 1'b1);
        wait_done("t3", 120);
        rdy_mode = 0;
        ed = '{'h31, 'h32, 'h33, 'h34, 'h35, 'h41, 'h42};
        et = '{0, 0, 0, 0, 0, 1, 1};
        check_seq("t3");
        chk("t3_cnt0", cnt0, 16'd1);
        chk("t3_cnt1", cnt1, 16'd1);

        // Continuous single-beat packets on both ports: strict alternation
        reset_dut();
        for (int i = 0; i < 4; i++) push(0, 'hA0 + i, 1'b1);
        for (int i = 0; i < 4; i++) push(1, 'hB0 + i, 1'b1);
        wait_done("t4", 60);
        ed = '{'hA0, 'hB0, 'hA1, 'hB1, 'hA2, 'hB2, 'hA3, 'hB3};
        et = '{0, 1, 0, 1, 0, 1, 0, 1};
        check_seq("t4");
        chk("t4_cnt0", cnt0, 16'd4);
        chk("t4_cnt1", cnt1, 16'd4);

        // Reset in the middle of a port-0 packet
        reset_dut();
        for (int i = 1; i <= 4; i++) push(0, 'h50 + i, i == 4);
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (q0.size() != 2 && n < 40);
        rst = 1'b1;
        push(1, 'h61, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_busy",      busy,      1'b0);
        chk("t5_s0_tready", s0.tready, 1'b0);
        chk("t5_s1_tready", s1.tready, 1'b0);
        chk("t5_cnt0",      cnt0,      16'd0);
        wait_done("t5", 40);
        ed = '{'h51, 'h52, 'h53, 'h54, 'h61};
        et = '{0, 0, 0, 0, 1};
        check_seq("t5");
        chk("t5_cnt0_after", cnt0, 16'd1);
        chk("t5_cnt1_after", cnt1, 16'd1);

        // 4-bit counter instance: 17 single-beat packets wrap to 1
        reset_dut();
        w0.tvalid = 1'b1;
        w0.tlast  = 1'b1;
        w0.tdata  = '0;
        n = 0;
        seen_wrap = 1'b0;
        prev = int'(wcnt0);
        for (int k = 0; k < 200 && n < 17; k++) begin
            @(negedge clk);
            hs = w0.tvalid && w0.tready;
            if (prev == 15 && wcnt0 == 4'h0) seen_wrap = 1'b1;
            prev = int'(wcnt0);
            @(posedge clk);
            #1;
            if (hs) begin
                n++;
                w0.tdata = n;
            end
            if (n == 17) w0.tvalid = 1'b0;
        end
        w0.tvalid = 1'b0;
        @(negedge clk);
        chk("t6_packets",  n,         17);
        chk("t6_wrap_seen", seen_wrap, 1'b1);
        chk("t6_cnt0",     wcnt0,     4'h1);
        chk("t6_cnt1",     wcnt1,     4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
